// File: rtl/tt_um_zoelus_uart_tx.sv
// Strobe-fed byte FIFO drained as UART frames on uio[1].
// Define UART_TX_PARITY_EN for 8E1 frames; default build is 8N1.
module tt_um_zoelus_uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = 10;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;

  state_e         state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     sh_q, sh_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic [2:0]     s_q;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           push, pop, push_ok;
  logic           full, empty, done;
  logic [3:0]     cnt4;
`ifdef UART_TX_PARITY_EN
  logic           par_q, par_d;
`endif
  logic           unused_ok;

  assign unused_ok = ^{ena, uio_in[7:1]};

  assign push    = s_q[1] & ~s_q[2];
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign done    = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign push_ok = push & (~full | pop);
  assign cnt4    = 4'(cnt_q);

  // FIFO bookkeeping and sticky overflow on dropped pushes
  always_comb begin
    ovf_d = ovf_q | (push & full & ~pop);
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
    wr_d  = wr_q + AW'(push_ok);
    rd_d  = rd_q + AW'(pop);
  end

  // FSM next state, shift register and registered pin values
  always_comb begin
    state_d = state_q;
    baud_d  = done ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = mem_q[rd_q];
          state_d = START;
        end
      end
      START: begin
        if (done) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (done) begin
          sh_d  = {1'b0, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (done) state_d = STOP;
      end
      STOP: begin
        if (done) begin
          if (!empty) begin
            pop     = 1'b1;
            sh_d    = mem_q[rd_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_TX_PARITY_EN
    if (pop) par_d = ^mem_q[rd_q];
`endif
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) | (cnt_d != '0);
  end

  // State, datapath and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      s_q     <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      s_q     <= {s_q[1:0], uio_in[0]};
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care once pointers reset
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= ui_in;
  end

  assign uo_out  = {ovf_q, tx_q, busy_q, full, cnt4};
  assign uio_out = {5'b0, busy_q, tx_q, 1'b0};
  assign uio_oe  = 8'b0000_0110;

endmodule

// File: tb/tb_tt_um_zoelus_uart_tx.sv
// Bench for tt_um_zoelus_uart_tx: frame-level model plus directed cases.
// Uses CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_tt_um_zoelus_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 44;
`else
  localparam int FL = 40;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int errors = 0;

  tt_um_zoelus_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .ui_in(ui_in),
    .uo_out(uo_out),
    .uio_in(uio_in),
    .uio_out(uio_out),
    .uio_oe(uio_oe),
    .ena(ena),
    .clk(clk),
    .rst_n(rst_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: strobe history, byte queue, current frame
  bit         h1, h2, h3;
  logic [7:0] q[$];
  bit         act, ovf;
  int         fs, n;
  logic [7:0] cur;

  always @(posedge clk) begin
    bit pu, po;
    int cnt;
    if (!rst_n) begin
      h1 = 0; h2 = 0; h3 = 0;
      q.delete();
      act = 0; ovf = 0; n = 0; fs = 0; cur = 8'h00;
    end else begin
      n++;
      pu = h2 && !h3;
      h3 = h2; h2 = h1; h1 = uio_in[0];
      cnt = q.size();
      po = (cnt > 0) && (!act || (n - fs) == FL);
      if (act && (n - fs) == FL && !po) act = 0;
      if (po) begin
        cur = q.pop_front();
        fs = n;
        act = 1;
      end
      if (pu) begin
        if (cnt < DEPTH || po) q.push_back(ui_in);
        else ovf = 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic       tx, busy, full;
    logic [3:0] c;
    int         k;
    tx = 1'b1;
    if (act) begin
      k = (n - fs) / CPB;
      if (k == 0) tx = 1'b0;
      else if (k <= 8) tx = cur[k-1];
`ifdef UART_TX_PARITY_EN
      else if (k == 9) tx = ^cur;
`endif
    end
    busy = act || (q.size() > 0);
    c = 4'(q.size());
    full = (q.size() == DEPTH);
    chk("uo_out", int'(uo_out), int'({ovf, tx, busy, full, c}));
    chk("uio_out", int'(uio_out), int'({5'b0, busy, tx, 1'b0}));
    chk("uio_oe", int'(uio_oe), 8'h06);
  end

  task automatic strobe(input logic [7:0] v);
    @(negedge clk); #1;
    ui_in = v;
    uio_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    #1 uio_in[0] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic capture(output int lat, output logic [7:0] data,
                         output logic par, output logic stopb,
                         output int len);
    logic fr [0:63];
    lat = -1;
    len = -1;
    data = 8'h00;
    par = 1'b0;
    stopb = 1'b0;
    for (int i = 0; i < 64; i++) fr[i] = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (!uo_out[6]) begin
        lat = i;
        break;
      end
    end
    if (lat > 0) begin
      fr[0] = 1'b0;
      for (int c = 1; c < 64; c++) begin
        @(posedge clk); #1;
        fr[c] = uo_out[6];
        if (!uo_out[5]) begin
          len = c;
          break;
        end
      end
      for (int j = 0; j < 8; j++) data[j] = fr[4*(j+1)+1];
      par = fr[37];
      stopb = fr[4*(FL/4-1)+1];
    end
  endtask

  int         lat, len;
  logic [7:0] d;
  logic       p, sb;

  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    repeat (100) @(negedge clk);
    chk("reset_uo_out", int'(uo_out), 8'h40);
    chk("reset_uio_out", int'(uio_out), 8'h02);
    chk("reset_uio_oe", int'(uio_oe), 8'h06);

    fork
      strobe(8'hA5);
      capture(lat, d, p, sb, len);
    join
    chk("a5_latency", lat, 4);
    chk("a5_data", int'(d), 8'hA5);
    chk("a5_stop", int'(sb), 1);
    chk("a5_len", len, FL);
    repeat (10) @(negedge clk);
    chk("a5_busy_after", int'(uo_out[5]), 0);

    for (int i = 1; i <= 5; i++) strobe(8'(i));
    chk("five_full", int'(uo_out[4]), 1);
    chk("five_count", int'(uo_out[3:0]), 4);
    repeat (300) @(negedge clk);
    chk("five_ovf", int'(uo_out[7]), 0);
    chk("five_idle", int'(uo_out[5]), 0);

    for (int i = 1; i <= 6; i++) strobe(8'(i));
    chk("six_ovf", int'(uo_out[7]), 1);
    chk("six_count", int'(uo_out[3:0]), 3);
    repeat (300) @(negedge clk);
    chk("six_ovf_sticky", int'(uo_out[7]), 1);
    chk("six_idle", int'(uo_out[5]), 0);

    ui_in = 8'h3C;
    @(negedge clk); #1 uio_in[0] = 1'b1;
    repeat (30) @(negedge clk);
    #1 uio_in[0] = 1'b0;
    repeat (60) @(negedge clk);
    chk("hold_one_frame", int'(uo_out[5]), 0);

    strobe(8'hFF);
    repeat (6) @(negedge clk);
    chk("ff_busy_mid", int'(uo_out[5]), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ff_rst_tx", int'(uio_out[1]), 1);
    chk("ff_rst_uo", int'(uo_out), 8'h40);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("ff_no_residual", int'(uo_out), 8'h40);

    strobe(8'h00);
    repeat (6) @(negedge clk);
    chk("z_tx_mid", int'(uio_out[1]), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("z_rst_tx", int'(uio_out[1]), 1);
    chk("z_rst_count", int'(uo_out[3:0]), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("z_no_residual", int'(uio_out), 8'h02);

    fork
      strobe(8'h07);
      capture(lat, d, p, sb, len);
    join
    chk("x07_latency", lat, 4);
    chk("x07_data", int'(d), 8'h07);
    chk("x07_len", len, FL);
`ifdef UART_TX_PARITY_EN
    chk("x07_parity", int'(p), 1);
`endif
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
